rowwise_operation_lanes: RTL and testbench

//   Multi-lane, runtime-configurable successor to the single-op row-wise unit.

---
 rtl/rowwise_operation_lanes_if.sv | 27 ++
 rtl/rowwise_operation_lanes.sv | 171 +++++++++++++++++
 tb/tb_rowwise_operation_lanes.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rowwise_operation_lanes_if.sv
// Handshake bundle for the row-wise lane unit: one input vector pair in, one result vector out.
// The master side is the producer/consumer pair, the slave side is the lane unit.
interface rowwise_operation_lanes_if #(
    parameter int D     = 64,
    parameter int WIDTH = 16
);
    logic [D*WIDTH-1:0] a_i;
    logic [D*WIDTH-1:0] b_i;
    logic [2:0]         op_i;
    logic               bcast_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [D*WIDTH-1:0] vector_o;
    logic               sat_o;
    logic               out_valid_o;
    logic               out_ready_i;

    modport master (
        output a_i, b_i, op_i, bcast_i, in_valid_i, out_ready_i,
        input  in_ready_o, vector_o, sat_o, out_valid_o
    );

    modport slave (
        input  a_i, b_i, op_i, bcast_i, in_valid_i, out_ready_i,
        output in_ready_o, vector_o, sat_o, out_valid_o
    );
endinterface

// File: rtl/rowwise_operation_lanes.sv
// Multi-lane row-wise vector unit: applies PASS/ADD/SUB/MUL/MAX/MIN element-wise on a captured
// vector pair, LANES elements per beat, with saturating fixed-point results and a sticky sat flag.
module rowwise_operation_lanes #(
    parameter int D     = 64,
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    rowwise_operation_lanes_if.slave bus
);
    if (LANES < 1 || LANES > D || (D % LANES) != 0 || FRAC >= WIDTH || FRAC < 0) begin : g_bad_cfg
        $error("rowwise_operation_lanes: invalid D/LANES/FRAC configuration");
    end

    localparam int N  = D / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(D) + 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

    localparam logic signed [WIDTH-1:0]   SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] SMAX_W = {{WIDTH{1'b0}}, SMAX};
    localparam logic signed [2*WIDTH-1:0] SMIN_W = {{WIDTH{1'b1}}, SMIN};

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_MAX  = 3'd4;
    localparam logic [2:0] OP_MIN  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORKING,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [D*WIDTH-1:0] a_q, a_d;
    logic [D*WIDTH-1:0] b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               bcast_q, bcast_d;
    logic [D*WIDTH-1:0] res_q, res_d;
    logic               sat_q, sat_d;

    logic [IW-1:0]          base;
    logic [LANES*WIDTH-1:0] lane_res;
    logic [LANES-1:0]       lane_sat;

    // Returns {saturated, clamped value}; every op is widened to 2*WIDTH before clamping.
    function automatic logic [WIDTH:0] clamp(input logic signed [2*WIDTH-1:0] v);
        if (v > SMAX_W) begin
            return {1'b1, SMAX};
        end else if (v < SMIN_W) begin
            return {1'b1, SMIN};
        end
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    assign base = IW'(cnt_q) * IW'(LANES);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IW-1:0]             idx;
        logic signed [WIDTH-1:0]   ea;
        logic signed [WIDTH-1:0]   eb;
        logic signed [WIDTH:0]     sum;
        logic signed [WIDTH:0]     dif;
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH-1:0] prod_sh;
        logic [WIDTH-1:0]          res;
        logic                      sat;

        always_comb begin
            idx     = base + IW'(gi);
            ea      = a_q[idx*WIDTH +: WIDTH];
            eb      = bcast_q ? b_q[WIDTH-1:0] : b_q[idx*WIDTH +: WIDTH];
            sum     = {ea[WIDTH-1], ea} + {eb[WIDTH-1], eb};
            dif     = {ea[WIDTH-1], ea} - {eb[WIDTH-1], eb};
            prod    = ea * eb;
            // Arithmetic shift floors toward -inf, which is the intended rounding.
            prod_sh = prod >>> FRAC;
            res     = '0;
            sat     = 1'b0;
            case (op_q)
                OP_PASS: res = ea;
                OP_ADD:  {sat, res} = clamp({{(WIDTH-1){sum[WIDTH]}}, sum});
                OP_SUB:  {sat, res} = clamp({{(WIDTH-1){dif[WIDTH]}}, dif});
                OP_MUL:  {sat, res} = clamp(prod_sh);
                OP_MAX:  res = (ea > eb) ? ea : eb;
                OP_MIN:  res = (ea < eb) ? ea : eb;
                default: ;
            endcase
        end

        assign lane_res[gi*WIDTH +: WIDTH] = res;
        assign lane_sat[gi]                = sat;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        bcast_d = bcast_q;
        res_d   = res_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    op_d    = bus.op_i;
                    bcast_d = bus.bcast_i;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = S_WORKING;
                end
            end
            S_WORKING: begin
                for (int i = 0; i < LANES; i++) begin
                    res_d[(base + IW'(i))*WIDTH +: WIDTH] = lane_res[i*WIDTH +: WIDTH];
                end
                sat_d = sat_q | (|lane_sat);
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            bcast_q <= 1'b0;
            res_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            bcast_q <= bcast_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.vector_o    = res_q;
    assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_rowwise_operation_lanes.sv
// Directed plus randomized bench for rowwise_operation_lanes (D=8, LANES=4, WIDTH=16, FRAC=8)
// against an integer-arithmetic reference model of the element operations.
module tb_rowwise_operation_lanes;
    localparam int D     = 8;
    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int N     = D / LANES;

    logic clk;
    logic rst;

    rowwise_operation_lanes_if #(.D(D), .WIDTH(WIDTH)) bus ();

    rowwise_operation_lanes #(.D(D), .LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int txn_no = 0;

    logic [15:0]  ta [D];
    logic [15:0]  tbv [D];
    logic [127:0] exp_vec;
    logic         exp_sat;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Element result from the arithmetic rules, using plain integers.
    function automatic int elem(input int op, input int a, input int b, output bit s);
        int r;
        int p;
        s = 1'b0;
        case (op)
            0: r = a;
            1: r = a + b;
            2: r = a - b;
            3: begin
                p = a * b;
                r = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
            end
            4: r = (a > b) ? a : b;
            5: r = (a < b) ? a : b;
            default: r = 0;
        endcase
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        return r;
    endfunction

    task automatic model(input int op, input bit bc);
        int r;
        bit s;
        logic [15:0] r16;
        exp_vec = '0;
        exp_sat = 1'b0;
        for (int k = 0; k < D; k++) begin
            r = elem(op, int'($signed(ta[k])), int'($signed(bc ? tbv[0] : tbv[k])), s);
            r16 = r[15:0];
            exp_vec[k*16 +: 16] = r16;
            exp_sat = exp_sat | s;
        end
    endtask

    function automatic logic [15:0] rnd16();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'($urandom_range(0, 1023)) - 16'd512;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic fill(input logic [15:0] av, input logic [15:0] bv);
        for (int k = 0; k < D; k++) begin
            ta[k]  = av;
            tbv[k] = bv;
        end
    endtask

    task automatic drive_inputs(input int op, input bit bc);
        for (int k = 0; k < D; k++) begin
            bus.a_i[k*16 +: 16] = ta[k];
            bus.b_i[k*16 +: 16] = tbv[k];
        end
        bus.op_i    = 3'(op);
        bus.bcast_i = bc;
    endtask

    task automatic scramble_inputs();
        bus.a_i     = {$urandom, $urandom, $urandom, $urandom};
        bus.b_i     = {$urandom, $urandom, $urandom, $urandom};
        bus.op_i    = 3'($urandom_range(0, 7));
        bus.bcast_i = 1'($urandom_range(0, 1));
    endtask

    task automatic run_txn(input string tag, input int op, input bit bc, input int hold);
        int w;
        int lat;
        model(op, bc);
        drive_inputs(op, bc);
        bus.in_valid_i = 1'b1;
        w = 0;
        while (!bus.in_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 128'(bus.in_ready_o), 128'(1));
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!bus.out_valid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(N));
        check({tag, "_vector"}, bus.vector_o, exp_vec);
        check({tag, "_sat"}, 128'(bus.sat_o), 128'(exp_sat));
        check({tag, "_busy_ready"}, 128'(bus.in_ready_o), 128'(0));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid_i = 1'b1;
            scramble_inputs();
            @(negedge clk);
            check({tag, "_hold_valid"}, 128'(bus.out_valid_o), 128'(1));
            check({tag, "_hold_ready"}, 128'(bus.in_ready_o), 128'(0));
            check({tag, "_hold_vector"}, bus.vector_o, exp_vec);
            check({tag, "_hold_sat"}, 128'(bus.sat_o), 128'(exp_sat));
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        check({tag, "_idle_valid"}, 128'(bus.out_valid_o), 128'(0));
        check({tag, "_idle_ready"}, 128'(bus.in_ready_o), 128'(1));
        check({tag, "_idle_vector"}, bus.vector_o, exp_vec);
        $display("txn %0d %s op=%0d bcast=%0b lat=%0d hold=%0d vec=%032h sat=%0b",
                 txn_no, tag, op, bc, lat, hold, bus.vector_o, bus.sat_o);
        txn_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst             = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        check("reset_in_ready", 128'(bus.in_ready_o), 128'(1));
        check("reset_out_valid", 128'(bus.out_valid_o), 128'(0));
        check("reset_vector", bus.vector_o, 128'(0));
        check("reset_sat", 128'(bus.sat_o), 128'(0));
        bus.in_valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        fill(16'h0100, 16'h0280);
        run_txn("add_basic", 1, 1'b0, 0);

        fill(16'h0000, 16'h0000);
        ta[3]  = 16'h7F00;
        tbv[3] = 16'h0200;
        run_txn("add_sat", 1, 1'b0, 0);

        fill(16'h8100, 16'h0200);
        run_txn("sub_sat", 2, 1'b0, 0);

        fill(16'h0180, 16'h7FFF);
        tbv[0] = 16'hFE00;
        run_txn("mul_bcast", 3, 1'b1, 0);

        fill(16'h0001, 16'hFF80);
        run_txn("mul_trunc", 3, 1'b0, 0);

        for (int k = 0; k < D; k++) begin
            ta[k]  = rnd16();
            tbv[k] = rnd16();
        end
        run_txn("backpressure", 1, 1'b0, 10);
        fill(16'h0123, 16'h0011);
        run_txn("after_bp", 2, 1'b0, 0);

        // Reset asserted while beat 1 is pending; the transaction must vanish.
        fill(16'h0400, 16'h0100);
        drive_inputs(1, 1'b0);
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(bus.in_ready_o), 128'(1));
        check("midrst_out_valid", 128'(bus.out_valid_o), 128'(0));
        check("midrst_vector", bus.vector_o, 128'(0));
        check("midrst_sat", 128'(bus.sat_o), 128'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_output", 128'(bus.out_valid_o), 128'(0));
        end
        $display("txn %0d reset_mid_op dropped", txn_no);
        txn_no++;

        fill(16'hFF00, 16'h0080);
        run_txn("max", 4, 1'b0, 0);
        run_txn("min", 5, 1'b0, 0);

        for (int k = 0; k < D; k++) begin
            ta[k]  = 16'h7F00;
            tbv[k] = 16'h7F00;
        end
        run_txn("reserved6", 6, 1'b0, 0);
        run_txn("reserved7", 7, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < D; k++) begin
                ta[k]  = rnd16();
                tbv[k] = rnd16();
            end
            run_txn("random", int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
